divider: RTL and testbench

//   IEEE-754 binary32 divider: result = in1 / in2.

---
 rtl/div_pkg.sv | 20 ++
 rtl/divider_classify.sv | 24 ++
 rtl/divider.sv | 208 ++++++++++++++++++++
 tb/tb_divider.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and types for the binary32 iterative divider.
package div_pkg;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 1;
    localparam int Q_W    = 27;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    localparam int FLG_INVALID   = 4;
    localparam int FLG_DIVZERO   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_ROUND, S_DONE} state_t;
    typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} op_class_t;
endpackage

// File: rtl/divider_classify.sv
// Splits a binary32 operand into sign, exponent, hidden-bit mantissa and class.
// Subnormals are treated as zero.
module divider_classify
    import div_pkg::*;
(
    input  logic [31:0]        op,
    output logic               sign,
    output logic [EXP_W-1:0]   exp,
    output logic [MANT_W-1:0]  mant,
    output op_class_t          cls
);
    always_comb begin
        sign = op[31];
        exp  = op[30:23];
        mant = {1'b1, op[22:0]};
        if (op[30:23] == 8'h00) begin
            cls = CLS_ZERO;
        end else if (op[30:23] == 8'hFF) begin
            cls = (op[22:0] == 23'h0) ? CLS_INF : CLS_NAN;
        end else begin
            cls = CLS_NORM;
        end
    end
endmodule

// File: rtl/divider.sv
// binary32 restoring divider, RNE, FTZ/DAZ, fixed 29-edge latency.
// Optional flags output is enabled by defining DIV_FLAGS_EN.
module divider
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic        out_valid,
    output logic [31:0] result
`ifdef DIV_FLAGS_EN
    ,
    output logic [4:0]  flags
`endif
);
    localparam logic [4:0] NORM_CNT = 5'(Q_W);

    logic               s1, s2;
    logic [EXP_W-1:0]   e1, e2;
    logic [MANT_W-1:0]  m1, m2;
    op_class_t          c1, c2;

    divider_classify u_cls_a (.op(in1), .sign(s1), .exp(e1), .mant(m1), .cls(c1));
    divider_classify u_cls_b (.op(in2), .sign(s2), .exp(e2), .mant(m2), .cls(c2));

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [24:0]         rem_q, rem_d;
    logic [23:0]         mb_q, mb_d;
    logic [Q_W-1:0]      quo_q, quo_d;
    logic signed [9:0]   exp_q, exp_d;
    logic                sign_q, sign_d;
    logic                special_q, special_d;
    logic [31:0]         spec_res_q, spec_res_d;
    logic [31:0]         result_q, result_d;

    logic                spec_hit;
    logic [31:0]         spec_val;
    logic                sgn;
    logic                rem_ge;
    logic [23:0]         rem_sub;
    logic                guard, sticky, round_up, ovf, unf;
    logic [24:0]         mant_sum;
    logic signed [9:0]   exp_rnd;
    logic [22:0]         frac_rnd;

`ifdef DIV_FLAGS_EN
    logic [4:0] spec_flg, spec_flg_q, spec_flg_d, flags_q, flags_d;
`endif

    // Special-operand outcome is resolved at accept and replayed in ROUND.
    always_comb begin
        sgn      = s1 ^ s2;
        spec_hit = 1'b1;
        spec_val = QNAN;
`ifdef DIV_FLAGS_EN
        spec_flg = '0;
`endif
        if (c1 == CLS_NAN || c2 == CLS_NAN ||
            (c1 == CLS_ZERO && c2 == CLS_ZERO) || (c1 == CLS_INF && c2 == CLS_INF)) begin
`ifdef DIV_FLAGS_EN
            spec_flg[FLG_INVALID] = 1'b1;
`endif
        end else if (c1 == CLS_INF) begin
            spec_val = {sgn, POS_INF[30:0]};
        end else if (c2 == CLS_ZERO) begin
            spec_val = {sgn, POS_INF[30:0]};
`ifdef DIV_FLAGS_EN
            spec_flg[FLG_DIVZERO] = 1'b1;
`endif
        end else if (c1 == CLS_ZERO || c2 == CLS_INF) begin
            spec_val = {sgn, 31'h0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        mb_d       = mb_q;
        quo_d      = quo_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        result_d   = result_q;
`ifdef DIV_FLAGS_EN
        spec_flg_d = spec_flg_q;
        flags_d    = flags_q;
`endif
        // The partial remainder stays below the divisor before each shift, so 24 bits suffice.
        rem_ge   = rem_q >= {1'b0, mb_q};
        rem_sub  = rem_q[23:0] - mb_q;

        guard    = quo_q[2];
        sticky   = (|quo_q[1:0]) || (|rem_q);
        round_up = guard && (sticky || quo_q[3]);
        mant_sum = {1'b0, quo_q[26:3]} + {24'h0, round_up};
        exp_rnd  = mant_sum[24] ? exp_q + 10'sd1 : exp_q;
        frac_rnd = mant_sum[24] ? mant_sum[23:1] : mant_sum[22:0];
        ovf      = exp_rnd >= 10'sd255;
        unf      = exp_rnd <= 10'sd0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d    = S_DIV;
                    cnt_d      = 5'd0;
                    rem_d      = {1'b0, m1};
                    mb_d       = m2;
                    quo_d      = '0;
                    exp_d      = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'(BIAS);
                    sign_d     = sgn;
                    special_d  = spec_hit;
                    spec_res_d = spec_val;
`ifdef DIV_FLAGS_EN
                    spec_flg_d = spec_flg;
`endif
                end
            end
            S_DIV: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == NORM_CNT) begin
                    // Final DIV cycle normalises so that quo_q[26] is the leading one.
                    if (!quo_q[26]) begin
                        quo_d = {quo_q[25:0], 1'b0};
                        exp_d = exp_q - 10'sd1;
                    end
                    state_d = S_ROUND;
                end else begin
                    quo_d = {quo_q[25:0], rem_ge};
                    rem_d = rem_ge ? {rem_sub, 1'b0} : {rem_q[23:0], 1'b0};
                end
            end
            S_ROUND: begin
                if (special_q) begin
                    result_d = spec_res_q;
                end else if (ovf) begin
                    result_d = {sign_q, POS_INF[30:0]};
                end else if (unf) begin
                    result_d = {sign_q, 31'h0};
                end else begin
                    result_d = {sign_q, exp_rnd[7:0], frac_rnd};
                end
`ifdef DIV_FLAGS_EN
                if (special_q) begin
                    flags_d = spec_flg_q;
                end else begin
                    flags_d                = '0;
                    flags_d[FLG_OVERFLOW]  = ovf;
                    flags_d[FLG_UNDERFLOW] = unf;
                    flags_d[FLG_INEXACT]   = guard | sticky | ovf | unf;
                end
`endif
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            mb_q       <= '0;
            quo_q      <= '0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            mb_q       <= mb_d;
            quo_q      <= quo_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            result_q   <= result_d;
        end
    end

`ifdef DIV_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_flg_q <= '0;
            flags_q    <= '0;
        end else begin
            spec_flg_q <= spec_flg_d;
            flags_q    <= flags_d;
        end
    end
    assign flags = flags_q;
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed table, handshake/reset sequences,
// and random operands against a wide-integer reference model. Honours DIV_FLAGS_EN.
module tb_divider;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        out_valid;
    logic [31:0] result;
`ifdef DIV_FLAGS_EN
    logic [4:0]  flags;
`endif

    int n_vec = 0;
    int n_err = 0;
    int busy_ready = 0;

    always #5 clk = ~clk;

    divider dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .out_valid(out_valid), .result(result)
`ifdef DIV_FLAGS_EN
        , .flags(flags)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [4:0]  f;
    } vec_t;

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", what, act, exp);
        end
    endtask

    // Reference: classify, then divide with 38 extra bits of integer precision and round RNE.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [4:0] f);
        bit s, za, zb, ia, ib, na, nb, g, st;
        int e, sh;
        longint unsigned ma, mb, num, q, rm, mant, rest, half;
        s  = a[31] ^ b[31];
        za = (a[30:23] == 8'h00);
        zb = (b[30:23] == 8'h00);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
        ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
        na = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
        f  = 5'b00000;
        if (na || nb || (za && zb) || (ia && ib)) begin
            r = 32'h7FC00000; f = 5'b10000; return;
        end
        if (ia) begin r = {s, 8'hFF, 23'h0}; return; end
        if (zb) begin r = {s, 8'hFF, 23'h0}; f = 5'b01000; return; end
        if (za || ib) begin r = {s, 31'h0}; return; end
        ma  = {40'h0, 1'b1, a[22:0]};
        mb  = {40'h0, 1'b1, b[22:0]};
        num = ma << 38;
        q   = num / mb;
        rm  = num % mb;
        e   = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (q >= (64'd1 << 38)) sh = 15;
        else begin sh = 14; e = e - 1; end
        mant = q >> sh;
        rest = q & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        g    = (rest >= half);
        st   = ((rest & (half - 1)) != 0) || (rm != 0);
        if (g && (st || mant[0])) mant = mant + 1;
        if (mant == (64'd1 << 24)) begin mant = mant >> 1; e = e + 1; end
        if (e >= 255) begin
            r = {s, 8'hFF, 23'h0}; f = 5'b00101;
        end else if (e <= 0) begin
            r = {s, 31'h0}; f = 5'b00011;
        end else begin
            r = {s, 8'(e), 23'(mant)}; f = {4'b0000, g | st};
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] fr;
        int k;
        k  = $urandom_range(0, 11);
        fr = 23'($urandom);
        case (k)
            0: e = 8'h00;
            1: begin e = 8'hFF; if ($urandom_range(0, 1) == 0) fr = '0; end
            2: e = 8'($urandom_range(1, 30));
            3: e = 8'($urandom_range(225, 254));
            4: begin e = 8'($urandom_range(100, 154)); fr = {fr[22:12], 12'h000}; end
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, fr};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold,
                          output logic [31:0] res, output logic [4:0] flg, output int lat);
        int waited;
        bit seen;
        waited = 0;
        seen   = 1'b0;
        while (!in_ready && waited < 100) begin @(negedge clk); waited++; end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL ready_wait: in_ready=0, want 1");
        end
        in1 = a; in2 = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in1 = $urandom; in2 = $urandom;
        if (!hold) in_valid = 1'b0;
        lat = 0;
        while (!seen && lat < 60) begin
            @(posedge clk); lat++; #1;
            if (out_valid) seen = 1'b1;
            else if (in_ready) busy_ready++;
        end
        in_valid = 1'b0;
        res = result;
`ifdef DIV_FLAGS_EN
        flg = flags;
`else
        flg = 5'b00000;
`endif
        check("latency", 32'(lat), 32'd29);
        @(posedge clk); #1;
        check("pulse_width", {31'h0, out_valid}, 32'h0);
        check("result_hold", result, res);
        check("ready_after", {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[22];
        logic [31:0] res, exp_r;
        logic [4:0]  flg, exp_f;
        int          lat;
        bit          seen;

        vecs[0]  = '{32'h3F800000, 32'h40000000, 32'h3F000000, 5'b00000};
        vecs[1]  = '{32'hC0000000, 32'h40000000, 32'hBF800000, 5'b00000};
        vecs[2]  = '{32'h40400000, 32'h40400000, 32'h3F800000, 5'b00000};
        vecs[3]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001};
        vecs[4]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000};
        vecs[5]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000};
        vecs[6]  = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 5'b00000};
        vecs[7]  = '{32'h00000000, 32'hBF800000, 32'h80000000, 5'b00000};
        vecs[8]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000};
        vecs[9]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000};
        vecs[10] = '{32'hFFFFFFFF, 32'h3F800000, 32'h7FC00000, 5'b10000};
        vecs[11] = '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101};
        vecs[12] = '{32'h00800000, 32'h40000000, 32'h00000000, 5'b00011};
        vecs[13] = '{32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000};
        vecs[14] = '{32'h3F800000, 32'h80000001, 32'hFF800000, 5'b01000};
        vecs[15] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 5'b00000};
        vecs[16] = '{32'h40000000, 32'hFF800000, 32'h80000000, 5'b00000};
        vecs[17] = '{32'h3F800001, 32'h3F800000, 32'h3F800001, 5'b00000};
        vecs[18] = '{32'h3F7FFFFF, 32'h3F7FFFFE, 32'h3F800001, 5'b00001};
        vecs[19] = '{32'h00800000, 32'h3F800000, 32'h00800000, 5'b00000};
        vecs[20] = '{32'h00800000, 32'h3F800001, 32'h00000000, 5'b00011};
        vecs[21] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 5'b00000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {31'h0, in_ready}, 32'h1);
        check("reset_out_valid", {31'h0, out_valid}, 32'h0);
        check("reset_result", result, 32'h0);
`ifdef DIV_FLAGS_EN
        check("reset_flags", {27'h0, flags}, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 22; i++) begin
            run_op(vecs[i].a, vecs[i].b, 1'b0, res, flg, lat);
            $display("vec %0d: %h / %h -> %h flags %b lat %0d", i, vecs[i].a, vecs[i].b, res, flg, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].q);
`ifdef DIV_FLAGS_EN
            check($sformatf("vec%0d_flags", i), {27'h0, flg}, {27'h0, vecs[i].f});
`endif
        end

        // in_valid held high (with changing operands) for the whole divide
        run_op(32'h3F800000, 32'h40400000, 1'b1, res, flg, lat);
        $display("hold: 3f800000 / 40400000 -> %h lat %0d", res, lat);
        check("hold_result", res, 32'h3EAAAAAB);

        // Reset ten cycles into a divide
        in1 = 32'h40400000; in2 = 32'h3F800000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'h0, in_ready}, 32'h1);
        check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        $display("midrst: out_valid seen=%0d in_ready=%0d", seen, in_ready);
        check("midrst_no_valid", {31'h0, seen}, 32'h0);
        check("midrst_ready_after", {31'h0, in_ready}, 32'h1);

        // Random operands against the reference model
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a, b;
            a = rand_op();
            b = rand_op();
            ref_div(a, b, exp_r, exp_f);
            run_op(a, b, 1'b0, res, flg, lat);
            $display("rnd %0d: %h / %h -> %h (model %h) flags %b lat %0d", i, a, b, res, exp_r, flg, lat);
            check("rnd_result", res, exp_r);
`ifdef DIV_FLAGS_EN
            check("rnd_flags", {27'h0, flg}, {27'h0, exp_f});
`endif
        end

        check("busy_in_ready", 32'(busy_ready), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
